instr_fetch_unit: RTL

Instruction fetch stage of the KGP-RISC datapath, directly downstream of `PC_next`. It takes `npc` as the fetch address and runs a request/grant/response handshake to instruction memory. Returned instructions are buffered, tagged with their PC, in a small FIFO feeding the decode stage. A branch redirect flushes everything in flight.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/instr_fetch_unit_fifo.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/grant/response bus plus the decode-side output stream.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // imem: a request is accepted when imem_req && imem_gnt; imem_rvalid returns its word
  // one or more cycles later. Decode: the head is consumed when out_valid && out_ready,
  // and the head is held stable while out_valid && !out_ready.
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Small power-of-two FIFO of fetched {pc, instr} entries; head is read from the register file.
module fetch_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_pkg::fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  entry_t        push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW-1:0] count_o,
  output entry_t        head_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic          pop_en;
  logic          push_en;

  assign count_o = wptr_q - rptr_q;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == PW'(DEPTH));
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_en) begin
        mem_q[wptr_q[AW-1:0]] <= push_data_i;
        wptr_q                <= wptr_q + PW'(1);
      end
      if (pop_en) rptr_q <= rptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one-outstanding request FSM to instruction memory, PC tagging and
// a decode-side buffer, all discarded on a branch redirect.
module instr_fetch_unit #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DATA_W = fetch_pkg::DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_take,
  input  logic              flush,
  instr_fetch_unit_if.master bus,
  output logic [1:0]        dbg_state_o
);
  import fetch_pkg::*;

  localparam int PW = $clog2(DEPTH) + 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] aligned_addr;
  logic              resp_in_wait;
  logic              push;
  logic              pop;
  logic              room;
  logic              req;
  logic              take;
  logic [PW:0]       count_after;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PW-1:0]     fifo_count;
  entry_t            push_data;
  entry_t            head;

  assign aligned_addr = {pc_in[ADDR_W-1:2], 2'b00};
  assign resp_in_wait = (state_q == ST_WAIT) && bus.imem_rvalid;
  assign push         = resp_in_wait && !flush;
  assign pop          = bus.out_valid && bus.out_ready;

  // Occupancy once this cycle's push/pop settle; a new request needs a free slot for its reply.
  assign count_after  = {1'b0, fifo_count} + (PW+1)'(push) - (PW+1)'(pop);
  assign room         = count_after < (PW+1)'(DEPTH);

  assign req  = rst && !flush && room && ((state_q == ST_IDLE) || resp_in_wait);
  assign take = req && bus.imem_gnt;

  assign bus.imem_req  = req;
  assign bus.imem_addr = aligned_addr;
  assign pc_take       = take;
  assign dbg_state_o   = state_q;

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    if (take) req_pc_d = aligned_addr;
    case (state_q)
      ST_IDLE: begin
        if (take) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush)                  state_d = bus.imem_rvalid ? ST_IDLE : ST_DRAIN;
        else if (bus.imem_rvalid)   state_d = take ? ST_WAIT : ST_IDLE;
      end
      ST_DRAIN: begin
        // The stale reply ends the drain even if another redirect lands on the same cycle.
        if (bus.imem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign push_data.pc    = req_pc_q;
  assign push_data.instr = bus.imem_rdata;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (flush),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (head)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;

endmodule
